// File: rtl/calc_pkg.sv
// calc_pkg: shared state codes, ALU op encodings and register addresses
package calc_pkg;
    typedef enum logic [3:0] {
        S0_IDLE   = 4'd0,
        S1_LOAD1  = 4'd1,
        S2_LOAD2  = 4'd2,
        S3_EXEC   = 4'd3,
        S4_STORE  = 4'd4,
        S5_OUTPUT = 4'd5,
        S6_DONE   = 4'd6
    } state_t;
    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_NOT = 3'b101;
    localparam logic [2:0] OP_SHL = 3'b110;
    localparam logic [2:0] OP_SHR = 3'b111;
    localparam logic [1:0] RA_R1 = 2'd1;
    localparam logic [1:0] RA_R2 = 2'd2;
    localparam logic [1:0] RA_R3 = 2'd3;
endpackage

// File: rtl/reg_file_4x4.sv
// reg_file_4x4: 4 x W registers, one sync write port, two async read ports gated to 0 when disabled
module reg_file_4x4 #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_we,
    input  logic [1:0]   i_wa,
    input  logic [W-1:0] i_wd,
    input  logic         i_rea,
    input  logic [1:0]   i_ra,
    input  logic         i_reb,
    input  logic [1:0]   i_rb,
    output logic [W-1:0] o_rda,
    output logic [W-1:0] o_rdb
);
    logic [W-1:0] r_mem [4];

    // storage array, cleared by the active-low async reset
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_mem <= '{default: '0};
        else if (i_we) r_mem[i_wa] <= i_wd;
    end

    assign o_rda = i_rea ? r_mem[i_ra] : '0;
    assign o_rdb = i_reb ? r_mem[i_rb] : '0;
endmodule

// File: rtl/calc_ctrl_dp.sv
// calc_ctrl_dp: sequenced load/execute/store calculator with a 7-state controller and small ALU
module calc_ctrl_dp
    import calc_pkg::*;
#(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         Go,
    input  logic [2:0]   Op,
    input  logic [W-1:0] in1,
    input  logic [W-1:0] in2,
    output logic [3:0]   CS,
    output logic         Done,
    output logic [W-1:0] Out
);
    state_t       r_state, w_next;
    logic         r_go_q, r_armed, w_go_evt;
    logic [2:0]   r_op_q;
    logic [W-1:0] r_alu_q, r_out, w_alu, w_rda, w_rdb, w_wd;
    logic         w_we, w_rea, w_reb;
    logic [1:0]   w_wa, w_ra, w_rb;

    // r_armed stays low until Go is seen low, so a Go held across reset release cannot start an op
    assign w_go_evt = Go & ~r_go_q & r_armed;

    // Go history and arming for rising-edge detection
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_go_q  <= 1'b0;
            r_armed <= 1'b0;
        end else begin
            r_go_q  <= Go;
            r_armed <= r_armed | ~Go;
        end
    end

    // state register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S0_IDLE;
        else r_state <= w_next;
    end

    // next state and register-file port controls
    always_comb begin
        w_next = S0_IDLE;
        w_we   = 1'b0;
        w_wa   = RA_R1;
        w_wd   = r_alu_q;
        w_rea  = 1'b0;
        w_ra   = RA_R1;
        w_reb  = 1'b0;
        w_rb   = RA_R2;
        case (r_state)
            S0_IDLE:   w_next = w_go_evt ? S1_LOAD1 : S0_IDLE;
            S1_LOAD1:  begin w_next = S2_LOAD2;  w_we = 1'b1; w_wa = RA_R1; w_wd = in1; end
            S2_LOAD2:  begin w_next = S3_EXEC;   w_we = 1'b1; w_wa = RA_R2; w_wd = in2; end
            S3_EXEC:   begin w_next = S4_STORE;  w_rea = 1'b1; w_reb = 1'b1; end
            S4_STORE:  begin w_next = S5_OUTPUT; w_we = 1'b1; w_wa = RA_R3; end
            S5_OUTPUT: begin w_next = S6_DONE;   w_rea = 1'b1; w_ra = RA_R3; end
            S6_DONE:   w_next = w_go_evt ? S1_LOAD1 : S6_DONE;
            default:   w_next = S0_IDLE;
        endcase
    end

    // ALU on read ports A/B, all results wrap to W bits
    always_comb begin
        w_alu = '0;
        case (r_op_q)
            OP_ADD: w_alu = w_rda + w_rdb;
            OP_SUB: w_alu = w_rda - w_rdb;
            OP_AND: w_alu = w_rda & w_rdb;
            OP_OR:  w_alu = w_rda | w_rdb;
            OP_XOR: w_alu = w_rda ^ w_rdb;
            OP_NOT: w_alu = ~w_rda;
            OP_SHL: w_alu = w_rda << 1;
            OP_SHR: w_alu = w_rda >> 1;
            default: w_alu = '0;
        endcase
    end

    // op capture, ALU result and output registers, each loaded only in its own state
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op_q  <= '0;
            r_alu_q <= '0;
            r_out   <= '0;
        end else begin
            if (r_state == S1_LOAD1) r_op_q <= Op;
            if (r_state == S3_EXEC) r_alu_q <= w_alu;
            if (r_state == S5_OUTPUT) r_out <= w_rda;
        end
    end

    reg_file_4x4 #(.W(W)) u_rf (
        .clk   (clk),
        .rst   (rst),
        .i_we  (w_we),
        .i_wa  (w_wa),
        .i_wd  (w_wd),
        .i_rea (w_rea),
        .i_ra  (w_ra),
        .i_reb (w_reb),
        .i_rb  (w_rb),
        .o_rda (w_rda),
        .o_rdb (w_rdb)
    );

    assign CS   = r_state;
    assign Done = (r_state == S6_DONE);
    assign Out  = r_out;
endmodule

// File: tb/tb_calc_ctrl_dp.sv
// tb_calc_ctrl_dp: scoreboard bench for calc_ctrl_dp (W=4)
module tb_calc_ctrl_dp;
    logic       clk = 1'b0;
    logic       rst;
    logic       Go;
    logic [2:0] Op;
    logic [3:0] in1, in2;
    logic [3:0] CS;
    logic       Done;
    logic [3:0] Out;
    int         n_run = 0;
    int         n_fail = 0;
    logic [3:0] exp_q[$];

    calc_ctrl_dp #(.W(4)) dut (
        .clk  (clk),
        .rst  (rst),
        .Go   (Go),
        .Op   (Op),
        .in1  (in1),
        .in2  (in2),
        .CS   (CS),
        .Done (Done),
        .Out  (Out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_run++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [3:0] model(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
        int r;
        case (op)
            3'd0: r = (int'(a) + int'(b)) % 16;
            3'd1: r = (int'(a) - int'(b) + 16) % 16;
            3'd2: r = int'(a & b);
            3'd3: r = int'(a | b);
            3'd4: r = int'(a ^ b);
            3'd5: r = 15 - int'(a);
            3'd6: r = (int'(a) * 2) % 16;
            default: r = int'(a) / 2;
        endcase
        return 4'(r);
    endfunction

    // act: 0 plain, 1 extra Go pulse in S3, 2 change Op/in1/in2 in S4
    task automatic run_op(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b, input int act);
        logic [3:0] prev;
        logic [3:0] e;
        prev = Out;
        Op = op;
        in1 = a;
        in2 = b;
        exp_q.push_back(model(op, a, b));
        Go = 1'b1;
        for (int s = 1; s <= 6; s++) begin
            @(negedge clk);
            if (s == 1) Go = 1'b0;
            if (act == 1 && s == 3) Go = 1'b1;
            if (act == 1 && s == 4) Go = 1'b0;
            if (act == 2 && s == 4) begin
                Op = ~op;
                in1 = ~a;
                in2 = ~b;
            end
            chk("cs_seq", CS, s);
            if (s < 6) chk("out_hold", Out, prev);
        end
        chk("done", Done, 1);
        chk("sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("out", Out, e);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_s1;
        rst = 1'b0;
        Go = 1'b0;
        Op = 3'd0;
        in1 = 4'd0;
        in2 = 4'd0;
        repeat (2) @(negedge clk);
        chk("rst_cs", CS, 0);
        chk("rst_done", Done, 0);
        chk("rst_out", Out, 0);
        rst = 1'b1;
        @(negedge clk);
        chk("idle_cs", CS, 0);
        run_op(3'b000, 4'd5, 4'd3, 0);
        run_op(3'b001, 4'd3, 4'd5, 0);
        run_op(3'b110, 4'd9, 4'd0, 0);
        run_op(3'b111, 4'd9, 4'd6, 0);
        run_op(3'b000, 4'd15, 4'd1, 1);
        repeat (3) begin
            @(negedge clk);
            chk("s6_hold", CS, 6);
        end
        run_op(3'b100, 4'd12, 4'd10, 2);
        for (int i = 0; i < 8; i++)
            run_op(i[2:0], 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 0);
        Op = 3'b000;
        in1 = 4'd7;
        in2 = 4'd7;
        Go = 1'b1;
        @(negedge clk);
        Go = 1'b0;
        repeat (3) @(negedge clk);
        chk("pre_rst_cs", CS, 4);
        rst = 1'b0;
        #1;
        chk("async_rst_cs", CS, 0);
        chk("async_rst_out", Out, 0);
        chk("async_rst_done", Done, 0);
        Go = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        repeat (5) begin
            @(negedge clk);
            chk("go_held_idle", CS, 0);
        end
        Go = 1'b0;
        @(negedge clk);
        run_op(3'b010, 4'd6, 4'd3, 0);
        @(negedge clk);
        exp_q.push_back(model(3'b011, 4'd8, 4'd2));
        Op = 3'b011;
        in1 = 4'd8;
        in2 = 4'd2;
        Go = 1'b1;
        n_s1 = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (CS == 4'd1) n_s1++;
        end
        Go = 1'b0;
        chk("held_go_s1_count", n_s1, 1);
        chk("held_go_cs", CS, 6);
        chk("held_go_sb_size", exp_q.size(), 1);
        if (exp_q.size() > 0) chk("held_go_out", Out, exp_q.pop_front());
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
